multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 15, consecutive mem_ready-low cycles in a memory state before mem_timeout asserts (1..255).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  opcode  in  7  instruction[6:0] from the instruction register
  funct3  in  3  instruction[14:12]
  funct7_5  in  1  instruction[30]
  zero  in  1  ALU zero flag
  mem_ready  in  1  unified memory access complete this cycle
  mem_req  out  1  memory access requested
  PCWrite  out  1  PC register load enable
  AdrSrc  out  1  memory address select: 0 PC, 1 ALU result register
  MemWrite  out  1  memory write enable
  IRWrite  out  1  instruction/oldPC register load enable
  ResultSrc  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result
  ALUSrcA  out  2  00 PC, 01 oldPC, 10 RD1
  ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
  ALUControl  out  3  ALU operation
  ImmSrc  out  2  immediate format
  RegWrite  out  1  register file write enable
  state  out  4  current FSM state encoding
  mem_timeout  out  1  sticky memory timeout flag
  illegal  out  1  illegal opcode flag (see Configuration)

Function
REQ-003 SHALL implement a Moore FSM plus combinational ALU and immediate decoders; control outputs are a function of state, opcode, funct3, funct7_5, zero and mem_ready only.
REQ-004 SHALL use state encodings FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, ERROR 11.
REQ-005 SHALL transition: FETCH->DECODE when mem_ready=1, otherwise stay in FETCH. DECODE then goes by opcode: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1101111 to JAL; 1100011 to BEQ.
REQ-006 SHALL transition: MEMADR->MEMREAD (opcode 0000011) or MEMWRITE (0100011); MEMREAD->MEMWB when mem_ready=1; MEMWRITE->FETCH when mem_ready=1; MEMWB, ALUWB, BEQ->FETCH; EXECR, EXECI, JAL->ALUWB.
REQ-007 SHALL drive per state (all unlisted outputs 0, ALUOp 00):
  FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, IRWrite=mem_ready, PCUpdate=mem_ready.
  DECODE: ALUSrcA=01, ALUSrcB=01.
  MEMADR: ALUSrcA=10, ALUSrcB=01.
  MEMREAD: mem_req=1, AdrSrc=1.
  MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1.
  MEMWB: ResultSrc=01, RegWrite=1.
  ALUWB: RegWrite=1.
  EXECR: ALUSrcA=10, ALUOp=10.
  EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-008 SHALL compute PCWrite = PCUpdate OR (Branch AND zero).
REQ-009 SHALL decode ALUControl from ALUOp: 00->000 (add); 01->001 (sub); 10->by funct3: 000->001 if opcode[5] AND funct7_5, else 000; 010->101; 110->011; 111->010; other funct3 values->000.
REQ-010 SHALL decode ImmSrc from opcode: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-011 SHALL count consecutive mem_ready-low cycles while mem_req=1. The counter clears on mem_ready=1 or on leaving the memory state and saturates at TIMEOUT. mem_timeout sets when the count reaches TIMEOUT and stays set until reset; the FSM keeps waiting regardless.

Reset
REQ-012 SHALL, on rst_n low, asynchronously force state=FETCH, the wait counter to 0, mem_timeout=0 and illegal=0. Outputs then take their FETCH values, with mem_ready gating IRWrite and PCWrite.
REQ-013 SHALL abort any in-flight instruction when reset asserts mid-operation; no RegWrite or MemWrite SHALL be asserted while rst_n is low.

Configuration
REQ-014 SHALL honour macro MC_ILLEGAL_TRAP_EN. When defined, DECODE with any unlisted opcode goes to ERROR; ERROR asserts illegal=1, drives all enables to 0, and is left only by reset. When undefined, an unlisted opcode in DECODE returns to FETCH, illegal is tied to 0, and ERROR is unreachable.

Verification
REQ-015 SHALL cover: reset release with lw x1 (opcode 0000011) and mem_ready always 1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; 5 cycles per instruction.
REQ-016 SHALL cover: R-type sub (opcode 0110011, funct3 000, funct7_5=1) -> ALUControl=001 in EXECR; ALUWB RegWrite=1; 4 cycles.
REQ-017 SHALL cover: beq with zero=1 in BEQ -> PCWrite=1 and ALUControl=001; repeated with zero=0 -> PCWrite=0; 3 cycles each.
REQ-018 SHALL cover: sw with mem_ready held low 20 cycles in MEMWRITE -> MemWrite held at 1, mem_timeout set after 15 low cycles, FETCH entered the cycle after mem_ready=1.
REQ-019 SHALL cover: opcode 0000000 in DECODE -> with MC_ILLEGAL_TRAP_EN, state=11 and illegal=1 held until rst_n low; without it, state returns to 0 and illegal=0.
REQ-020 SHALL cover: rst_n pulsed low during MEMWB -> state=0 immediately (asynchronous), no RegWrite pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: Moore main FSM, ALU/immediate decoders and memory wait watchdog.
// Optional illegal-opcode trap state is enabled by defining MC_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state,
  output logic       mem_timeout,
  output logic       illegal
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       alu_op;
  logic             branch;
  logic             pc_update;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_ERROR;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:    state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ERROR:    state_d = S_ERROR;
`else
      S_ERROR:    state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore control outputs; only FETCH peeks at mem_ready for its load enables
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    alu_op    = 2'b00;
    branch    = 1'b0;
    pc_update = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);
  assign state   = state_q;

  // ALU decoder; subtract only for R-type with funct7[5] set
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoder
  always_comb begin
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Memory wait watchdog: count consecutive stalled cycles, saturating; flag is sticky
  always_comb begin
    cnt_d = '0;
    if (mem_req && !mem_ready) begin
      cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_ERROR);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (works with or without MC_ILLEGAL_TRAP_EN).
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] state;
  logic       mem_timeout;
  logic       illegal;

  int n_vec;
  int n_err;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .state      (state),
    .mem_timeout(mem_timeout),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    opcode = 7'b0000011;
    funct3 = 3'b010;
    funct7_5 = 1'b0;
    zero = 1'b0;
    mem_ready = 1'b1;
    #1;
    // Reset: FETCH values, mem_ready gating the load enables
    check("rst_state", 8'(state), 8'd0);
    check("rst_timeout", 8'(mem_timeout), 8'd0);
    check("rst_illegal", 8'(illegal), 8'd0);
    check("rst_mem_req", 8'(mem_req), 8'd1);
    check("rst_irwrite_rdy", 8'(IRWrite), 8'd1);
    check("rst_pcwrite_rdy", 8'(PCWrite), 8'd1);
    check("rst_regwrite", 8'(RegWrite), 8'd0);
    check("rst_memwrite", 8'(MemWrite), 8'd0);
    mem_ready = 1'b0;
    #1;
    check("rst_irwrite_nrdy", 8'(IRWrite), 8'd0);
    check("rst_pcwrite_nrdy", 8'(PCWrite), 8'd0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // lw: 0,1,2,3,4,0
    #1;
    check("lw_fetch_srcb", 8'(ALUSrcB), 8'd2);
    check("lw_fetch_res", 8'(ResultSrc), 8'd2);
    tick(); check("lw_s1", 8'(state), 8'd1);
    check("lw_dec_srca", 8'(ALUSrcA), 8'd1);
    check("lw_dec_srcb", 8'(ALUSrcB), 8'd1);
    check("lw_dec_regw", 8'(RegWrite), 8'd0);
    tick(); check("lw_s2", 8'(state), 8'd2);
    check("lw_madr_srca", 8'(ALUSrcA), 8'd2);
    check("lw_madr_regw", 8'(RegWrite), 8'd0);
    tick(); check("lw_s3", 8'(state), 8'd3);
    check("lw_mrd_adrsrc", 8'(AdrSrc), 8'd1);
    check("lw_mrd_memreq", 8'(mem_req), 8'd1);
    check("lw_mrd_regw", 8'(RegWrite), 8'd0);
    tick(); check("lw_s4", 8'(state), 8'd4);
    check("lw_mwb_regw", 8'(RegWrite), 8'd1);
    check("lw_mwb_res", 8'(ResultSrc), 8'd1);
    tick(); check("lw_s0", 8'(state), 8'd0);
    check("lw_fetch_regw", 8'(RegWrite), 8'd0);

    // R-type sub: 0,1,6,7,0
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick(); check("sub_s1", 8'(state), 8'd1);
    tick(); check("sub_s6", 8'(state), 8'd6);
    check("sub_aluctl", 8'(ALUControl), 8'd1);
    check("sub_srca", 8'(ALUSrcA), 8'd2);
    check("sub_srcb", 8'(ALUSrcB), 8'd0);
    tick(); check("sub_s7", 8'(state), 8'd7);
    check("sub_regw", 8'(RegWrite), 8'd1);
    check("sub_res", 8'(ResultSrc), 8'd0);
    tick(); check("sub_s0", 8'(state), 8'd0);

    // R-type and: funct3 111
    funct3 = 3'b111; funct7_5 = 1'b0;
    tick(); tick(); check("and_s6", 8'(state), 8'd6);
    check("and_aluctl", 8'(ALUControl), 8'd2);
    tick(); tick(); check("and_s0", 8'(state), 8'd0);

    // addi with funct7_5=1: opcode[5]=0 keeps add
    opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick(); check("addi_imm", 8'(ImmSrc), 8'd0);
    tick(); check("addi_s8", 8'(state), 8'd8);
    check("addi_aluctl", 8'(ALUControl), 8'd0);
    check("addi_srcb", 8'(ALUSrcB), 8'd1);
    tick(); check("addi_s7", 8'(state), 8'd7);
    tick(); check("addi_s0", 8'(state), 8'd0);

    // slti via EXECI
    funct3 = 3'b010; funct7_5 = 1'b0;
    tick(); tick(); check("slti_aluctl", 8'(ALUControl), 8'd5);
    tick(); tick();

    // beq taken then not taken: 0,1,10,0
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    tick(); check("beq_imm", 8'(ImmSrc), 8'd2);
    tick(); check("beqt_s10", 8'(state), 8'd10);
    check("beqt_pcw", 8'(PCWrite), 8'd1);
    check("beqt_aluctl", 8'(ALUControl), 8'd1);
    tick(); check("beqt_s0", 8'(state), 8'd0);
    zero = 1'b0;
    tick(); tick(); check("beqn_s10", 8'(state), 8'd10);
    check("beqn_pcw", 8'(PCWrite), 8'd0);
    check("beqn_aluctl", 8'(ALUControl), 8'd1);
    tick(); check("beqn_s0", 8'(state), 8'd0);

    // jal: 0,1,9,7,0
    opcode = 7'b1101111;
    tick(); check("jal_imm", 8'(ImmSrc), 8'd3);
    tick(); check("jal_s9", 8'(state), 8'd9);
    check("jal_pcw", 8'(PCWrite), 8'd1);
    check("jal_srca", 8'(ALUSrcA), 8'd1);
    check("jal_srcb", 8'(ALUSrcB), 8'd2);
    tick(); check("jal_s7", 8'(state), 8'd7);
    tick(); check("jal_s0", 8'(state), 8'd0);

    // sw with a 20-cycle memory stall
    opcode = 7'b0100011; funct3 = 3'b010;
    tick(); check("sw_imm", 8'(ImmSrc), 8'd1);
    tick(); check("sw_s2", 8'(state), 8'd2);
    mem_ready = 1'b0;
    tick(); check("sw_s5", 8'(state), 8'd5);
    check("sw_memw", 8'(MemWrite), 8'd1);
    check("sw_to_start", 8'(mem_timeout), 8'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sw_stall_state", 8'(state), 8'd5);
      check("sw_stall_memw", 8'(MemWrite), 8'd1);
      check($sformatf("sw_timeout_%0d", i), 8'(mem_timeout), (i >= 15) ? 8'd1 : 8'd0);
    end
    mem_ready = 1'b1;
    #1;
    check("sw_rdy_state", 8'(state), 8'd5);
    tick(); check("sw_s0", 8'(state), 8'd0);
    check("sw_sticky", 8'(mem_timeout), 8'd1);

    // Unlisted opcode in DECODE
    opcode = 7'b0000000;
    tick(); check("ill_s1", 8'(state), 8'd1);
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    check("ill_s11", 8'(state), 8'd11);
    check("ill_flag", 8'(illegal), 8'd1);
    check("ill_memreq", 8'(mem_req), 8'd0);
    check("ill_regw", 8'(RegWrite), 8'd0);
    tick(); tick();
    check("ill_hold_state", 8'(state), 8'd11);
    check("ill_hold_flag", 8'(illegal), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ill_rst_state", 8'(state), 8'd0);
    check("ill_rst_flag", 8'(illegal), 8'd0);
    tick();
    rst_n = 1'b1;
`else
    check("ill_s0", 8'(state), 8'd0);
    check("ill_flag", 8'(illegal), 8'd0);
`endif

    // Reset asserted mid-MEMWB aborts without a RegWrite pulse
    opcode = 7'b0000011;
    tick(); tick(); tick(); tick();
    check("abort_s4", 8'(state), 8'd4);
    check("abort_pre_regw", 8'(RegWrite), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_state", 8'(state), 8'd0);
    check("abort_regw", 8'(RegWrite), 8'd0);
    check("abort_memw", 8'(MemWrite), 8'd0);
    check("abort_timeout", 8'(mem_timeout), 8'd0);
    tick();
    check("abort_hold_state", 8'(state), 8'd0);
    check("abort_hold_regw", 8'(RegWrite), 8'd0);
    rst_n = 1'b1;
    tick(); check("post_rst_s1", 8'(state), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
